// File: rtl/bitonic_stream_adapter_if.sv
// rtl/bitonic_stream_adapter_if.sv - upstream, sort-block and downstream signals of the adapter
interface bitonic_stream_adapter_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int BLOCK_DEPTH = 1
);
   localparam int N = 2 ** BLOCK_DEPTH;

   logic [DATA_WIDTH-1:0]   in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [N*DATA_WIDTH-1:0] blk_data_in;
   logic                    blk_valid;
   logic [N*DATA_WIDTH-1:0] blk_data_out;
   logic                    blk_done;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      input  in_data, in_valid, blk_data_out, blk_done, out_ready,
      output in_ready, blk_data_in, blk_valid, out_data, out_valid
   );

   modport slave (
      output in_data, in_valid, blk_data_out, blk_done, out_ready,
      input  in_ready, blk_data_in, blk_valid, out_data, out_valid
   );
endinterface

// File: rtl/bitonic_stream_adapter.sv
// rtl/bitonic_stream_adapter.sv - serialises elements into a sort-block word and streams the result back out
module bitonic_stream_adapter #(
   parameter int DATA_WIDTH  = 8,
   parameter int BLOCK_DEPTH = 1,
   parameter int TIMEOUT     = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   bitonic_stream_adapter_if.master     bus,
   output logic                         timeout_err
);
   localparam int N      = 2 ** BLOCK_DEPTH;
   localparam int CNT_W  = (BLOCK_DEPTH > 0) ? BLOCK_DEPTH : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        elem_cnt;
   logic [CNT_W-1:0]        out_idx;
   logic [WAIT_W-1:0]       wait_cnt;
   logic [N*DATA_WIDTH-1:0] data_reg;
   logic [N*DATA_WIDTH-1:0] result_reg;
   logic                    terr_q;
   logic                    in_fire, out_fire, capture, timed_out;

   always_ff @(posedge clk) begin
      if (reset) state <= FILL;
      else       state <= state_next;
   end

   // blk_done is only looked at in WAIT, so strobes in other states fall through untouched
   always_comb begin
      state_next    = state;
      in_fire       = 1'b0;
      out_fire      = 1'b0;
      capture       = 1'b0;
      timed_out     = 1'b0;
      bus.in_ready  = 1'b0;
      bus.blk_valid = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         FILL: begin
            bus.in_ready = 1'b1;
            in_fire      = bus.in_valid;
            if (bus.in_valid && elem_cnt == LAST_IDX) state_next = LAUNCH;
         end
         LAUNCH: begin
            bus.blk_valid = 1'b1;
            state_next    = WAIT;
         end
         WAIT: begin
            if (bus.blk_done) begin
               capture    = 1'b1;
               state_next = DRAIN;
            end else if (wait_cnt == WAIT_LAST) begin
               timed_out  = 1'b1;
               state_next = FILL;
            end
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            out_fire      = bus.out_ready;
            if (bus.out_ready && out_idx == LAST_IDX) state_next = FILL;
         end
         default: state_next = FILL;
      endcase
      if (reset) begin
         in_fire       = 1'b0;
         out_fire      = 1'b0;
         capture       = 1'b0;
         timed_out     = 1'b0;
         bus.in_ready  = 1'b0;
         bus.blk_valid = 1'b0;
         bus.out_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         elem_cnt   <= '0;
         out_idx    <= '0;
         wait_cnt   <= '0;
         data_reg   <= '0;
         result_reg <= '0;
         terr_q     <= 1'b0;
      end else begin
         if (in_fire) begin
            data_reg[elem_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
            elem_cnt <= (elem_cnt == LAST_IDX) ? '0 : elem_cnt + CNT_W'(1);
         end
         if (state == LAUNCH)    wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
         if (capture)   result_reg <= bus.blk_data_out;
         if (timed_out) terr_q     <= 1'b1;
         if (out_fire) begin
            out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + CNT_W'(1);
         end
      end
   end

   assign bus.blk_data_in = reset ? '0 : data_reg;
   assign bus.out_data    = reset ? '0 : result_reg[out_idx*DATA_WIDTH +: DATA_WIDTH];
   assign timeout_err     = terr_q & ~reset;
endmodule

// File: tb/tb_bitonic_stream_adapter.sv
// tb/tb_bitonic_stream_adapter.sv - randomized self-checking bench with an in-bench sort-block model
module tb_bitonic_stream_adapter;
   localparam int DW  = 8;
   localparam int BD  = 2;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic reset;
   logic timeout_err;
   int   checks = 0;
   int   errors = 0;
   bit   exp_terr = 1'b0;

   bitonic_stream_adapter_if #(.DATA_WIDTH(DW), .BLOCK_DEPTH(BD)) bus();

   bitonic_stream_adapter #(.DATA_WIDTH(DW), .BLOCK_DEPTH(BD), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .bus(bus), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ascending sort; smallest element ends up in element 0
   function automatic logic [31:0] sort_word(input logic [31:0] w);
      logic [7:0] a [4];
      logic [7:0] t;
      for (int i = 0; i < 4; i++) a[i] = w[i*8 +: 8];
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 3 - i; k++)
            if (a[k] > a[k+1]) begin t = a[k]; a[k] = a[k+1]; a[k+1] = t; end
      return {a[3], a[2], a[1], a[0]};
   endfunction

   // latency 0 = sort block never answers; stall_mode 0 always ready, 1 random, 2 pattern 1,0,0,1
   task automatic do_frame(input logic [31:0] word, input int latency, input int stall_mode,
                           input bit gaps, input bit hold_valid, input bit spurious);
      logic [31:0] srt;
      int k, budget, dc, j, nwait;
      bit rdy, sp_done;
      srt = sort_word(word);
      k = 0; budget = 0; sp_done = 0;
      while (k < 4) begin
         if (budget >= 100) begin
            errors++; $display("FAIL fill_budget accepted=%0d required=4", k); return;
         end
         bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.in_data  = word[k*8 +: 8];
         if (spurious && k == 2 && !sp_done) begin
            bus.blk_done = 1'b1; bus.blk_data_out = 32'hDEADBEEF; sp_done = 1;
         end
         #1;
         checks++;
         if ({bus.in_ready, bus.blk_valid, bus.out_valid} !== 3'b100) begin
            errors++; $display("FAIL fill_ctrl rdy/bv/ov=%b required=100", {bus.in_ready, bus.blk_valid, bus.out_valid});
         end
         if (bus.in_valid) k++;
         tick(); budget++;
         bus.blk_done = 1'b0;
      end
      bus.in_valid = hold_valid; bus.in_data = 8'hEE;
      #1;
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL launch_ctrl blk_valid=%b in_ready=%b required 1/0", bus.blk_valid, bus.in_ready);
      end
      checks++;
      if (bus.blk_data_in !== word) begin
         errors++; $display("FAIL launch_word got=%h required=%h", bus.blk_data_in, word);
      end
      tick();
      nwait = (latency == 0) ? TMO : latency;
      for (int c = 1; c <= nwait; c++) begin
         if (c == latency) begin bus.blk_done = 1'b1; bus.blk_data_out = srt; end
         #1;
         checks++;
         if ({bus.blk_valid, bus.in_ready, bus.out_valid} !== 3'b000) begin
            errors++; $display("FAIL wait_ctrl bv/rdy/ov=%b required=000 cycle=%0d", {bus.blk_valid, bus.in_ready, bus.out_valid}, c);
         end
         checks++;
         if (bus.blk_data_in !== word || timeout_err !== exp_terr) begin
            errors++; $display("FAIL wait_hold word=%h terr=%b required %h/%b", bus.blk_data_in, timeout_err, word, exp_terr);
         end
         tick();
         bus.blk_done = 1'b0; bus.blk_data_out = $urandom;
      end
      if (latency == 0) begin
         bus.in_valid = 1'b0;
         #1;
         exp_terr = 1'b1;
         checks++;
         if ({timeout_err, bus.in_ready, bus.out_valid} !== 3'b110) begin
            errors++; $display("FAIL timeout terr/rdy/ov=%b required=110", {timeout_err, bus.in_ready, bus.out_valid});
         end
         return;
      end
      j = 0; dc = 0;
      while (j < 4) begin
         if (dc >= 200) begin
            errors++; $display("FAIL drain_budget delivered=%0d required=4", j); return;
         end
         case (stall_mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 1) == 1);
            default: rdy = (dc >= 4) || dc == 0 || dc == 3;
         endcase
         bus.out_ready = rdy;
         if (spurious && dc == 1) begin bus.blk_done = 1'b1; bus.blk_data_out = 32'h5A5A5A5A; end
         #1;
         checks++;
         if ({bus.out_valid, bus.in_ready, bus.blk_valid} !== 3'b100) begin
            errors++; $display("FAIL drain_ctrl ov/rdy/bv=%b required=100", {bus.out_valid, bus.in_ready, bus.blk_valid});
         end
         checks++;
         if (bus.out_data !== srt[j*8 +: 8]) begin
            errors++; $display("FAIL drain_data idx=%0d got=%h required=%h", j, bus.out_data, srt[j*8 +: 8]);
         end
         if (rdy) j++;
         dc++;
         tick();
         bus.blk_done = 1'b0;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, timeout_err} !== {2'b01, exp_terr}) begin
         errors++; $display("FAIL frame_end ov/rdy/terr=%b required=01%b", {bus.out_valid, bus.in_ready, timeout_err}, exp_terr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      #1;
      checks++;
      if ({bus.out_valid, bus.blk_valid, timeout_err} !== 3'b000 || bus.blk_data_in !== 32'h0 || bus.out_data !== 8'h0) begin
         errors++; $display("FAIL reset_during ov/bv/terr=%b word=%h out=%h required 000/0/0",
                            {bus.out_valid, bus.blk_valid, timeout_err}, bus.blk_data_in, bus.out_data);
      end
      reset = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.blk_data_in !== 32'h0) begin
         errors++; $display("FAIL reset_after rdy=%b ov=%b word=%h required 1/0/0", bus.in_ready, bus.out_valid, bus.blk_data_in);
      end
      exp_terr = 1'b0;
   endtask

   task automatic test_spec_vector();
      do_frame(32'h20301040, 3, 0, 0, 0, 0);
   endtask

   task automatic test_stall();
      do_frame(32'h9C01F27E, 2, 2, 0, 0, 0);
   endtask

   task automatic test_latency_bounds();
      do_frame(32'h11223344, 1, 0, 0, 0, 0);
      do_frame(32'hFF00807F, TMO, 0, 0, 0, 0);
   endtask

   task automatic test_spurious_done();
      do_frame(32'h0A0B0C0D, 4, 1, 0, 0, 1);
   endtask

   task automatic test_random();
      for (int f = 0; f < 12; f++)
         do_frame($urandom, $urandom_range(1, TMO), 1, 1, 0, ($urandom_range(0, 3) == 0));
   endtask

   task automatic test_back_to_back();
      do_frame($urandom, 2, 0, 0, 1, 0);
      do_frame($urandom, 5, 0, 0, 1, 0);
   endtask

   task automatic test_timeout();
      do_frame(32'h01020304, 0, 0, 0, 0, 0);
      do_frame(32'h80706050, 6, 1, 0, 0, 0);
   endtask

   task automatic test_reset_midframe();
      bus.in_valid = 1'b1; bus.in_data = 8'hAA; tick();
      bus.in_data = 8'hBB; tick();
      reset = 1'b1; bus.in_valid = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.blk_valid, timeout_err} !== 3'b000 || bus.blk_data_in !== 32'h0) begin
         errors++; $display("FAIL midreset_during ov/bv/terr=%b word=%h required 000/0", {bus.out_valid, bus.blk_valid, timeout_err}, bus.blk_data_in);
      end
      tick();
      reset = 1'b0; exp_terr = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL midreset_after rdy=%b ov=%b terr=%b required 1/0/0", bus.in_ready, bus.out_valid, timeout_err);
      end
      do_frame(32'h44332211, 3, 0, 0, 0, 0);
   endtask

   task automatic test_reset_wait();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 8'(i + 1); tick();
      end
      bus.in_valid = 1'b0;
      tick(); tick();
      reset = 1'b1; tick();
      reset = 1'b0;
      bus.blk_done = 1'b1; bus.blk_data_out = 32'h04030201;
      tick();
      bus.blk_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({bus.out_valid, bus.blk_valid, bus.in_ready} !== 3'b001) begin
            errors++; $display("FAIL abort_frame ov/bv/rdy=%b required=001", {bus.out_valid, bus.blk_valid, bus.in_ready});
         end
         tick();
      end
      do_frame($urandom, 7, 1, 1, 0, 0);
   endtask

   initial begin
      reset            = 1'b1;
      bus.in_data      = '0;
      bus.in_valid     = 1'b0;
      bus.blk_data_out = '0;
      bus.blk_done     = 1'b0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_spec_vector();
      test_stall();
      test_latency_bounds();
      test_spurious_done();
      test_random();
      test_back_to_back();
      test_timeout();
      test_reset_midframe();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
